// File: rtl/io_port_decoder.sv
// Registered PicoBlaze port-ID decoder: windowed address decode into edge-qualified
// read/write select pulses, registered read-data mux and a sticky access-error log.
module io_port_decoder #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int NUM_PORTS = 16,
  parameter int BASE_ADDR = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [ADDR_W-1:0]         port_id,
  input  logic                      read_strobe,
  input  logic                      write_strobe,
  input  logic [DATA_W-1:0]         out_port,
  input  logic [NUM_PORTS*DATA_W-1:0] rd_data_bus,
  input  logic                      err_clr,
  output logic [DATA_W-1:0]         in_port,
  output logic [NUM_PORTS-1:0]      rd_sel,
  output logic [NUM_PORTS-1:0]      wr_sel,
  output logic [DATA_W-1:0]         wr_data,
  output logic                      err_flag,
  output logic [ADDR_W-1:0]         err_addr,
  output logic [7:0]                err_count
);

  localparam logic [ADDR_W:0] BASE_L = (ADDR_W+1)'(BASE_ADDR);
  localparam logic [ADDR_W:0] NUM_L  = (ADDR_W+1)'(NUM_PORTS);

  logic                 rd_q, wr_q;
  logic [DATA_W-1:0]    in_port_q, in_port_d;
  logic [NUM_PORTS-1:0] rd_sel_q, rd_sel_d;
  logic [NUM_PORTS-1:0] wr_sel_q, wr_sel_d;
  logic [DATA_W-1:0]    wr_data_q, wr_data_d;
  logic                 err_flag_q, err_flag_d;
  logic [ADDR_W-1:0]    err_addr_q, err_addr_d;
  logic [7:0]           err_count_q, err_count_d;

  logic [ADDR_W:0]      pid_x, off;
  logic                 hit, rd_ev, wr_ev, err_ev;
  logic [NUM_PORTS-1:0] onehot;
  logic [DATA_W-1:0]    rd_mux;

  // Offset is one bit wider than port_id so addresses below the base cannot wrap into range.
  always_comb begin
    pid_x = {1'b0, port_id};
    off   = pid_x - BASE_L;
    hit   = (pid_x >= BASE_L) && (off < NUM_L);
    rd_ev = read_strobe  & ~rd_q;
    wr_ev = write_strobe & ~wr_q;
    err_ev = ((rd_ev | wr_ev) & ~hit) | (rd_ev & wr_ev);
  end

  always_comb begin
    onehot = '0;
    rd_mux = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      if (hit && (off == (ADDR_W+1)'(k))) begin
        onehot[k] = 1'b1;
        rd_mux    = rd_data_bus[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    in_port_d   = rd_mux;
    wr_sel_d    = (wr_ev & hit) ? onehot : '0;
    rd_sel_d    = (rd_ev & hit & ~wr_ev) ? onehot : '0;
    wr_data_d   = (wr_ev & hit) ? out_port : wr_data_q;
    err_flag_d  = err_flag_q;
    err_addr_d  = err_addr_q;
    err_count_d = err_count_q;
    // A new error outranks a simultaneous clear: it restarts the log from this access.
    if (err_ev) begin
      err_flag_d = 1'b1;
      if (!err_flag_q || err_clr) err_addr_d = port_id;
      if (err_clr)                       err_count_d = 8'd1;
      else if (err_count_q != 8'hFF)     err_count_d = err_count_q + 8'd1;
    end else if (err_clr) begin
      err_flag_d  = 1'b0;
      err_addr_d  = '0;
      err_count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      in_port_q   <= '0;
      rd_sel_q    <= '0;
      wr_sel_q    <= '0;
      wr_data_q   <= '0;
      err_flag_q  <= 1'b0;
      err_addr_q  <= '0;
      err_count_q <= '0;
    end else begin
      rd_q        <= read_strobe;
      wr_q        <= write_strobe;
      in_port_q   <= in_port_d;
      rd_sel_q    <= rd_sel_d;
      wr_sel_q    <= wr_sel_d;
      wr_data_q   <= wr_data_d;
      err_flag_q  <= err_flag_d;
      err_addr_q  <= err_addr_d;
      err_count_q <= err_count_d;
    end
  end

  assign in_port   = in_port_q;
  assign rd_sel    = rd_sel_q;
  assign wr_sel    = wr_sel_q;
  assign wr_data   = wr_data_q;
  assign err_flag  = err_flag_q;
  assign err_addr  = err_addr_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_io_port_decoder.sv
// Directed bench for io_port_decoder with BASE_ADDR=0x10, NUM_PORTS=16;
// peripheral k returns 0x2D+k on its read-data slice.
module tb_io_port_decoder;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int NP = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [AW-1:0]  port_id = '0;
  logic           read_strobe = 1'b0;
  logic           write_strobe = 1'b0;
  logic [DW-1:0]  out_port = '0;
  logic [NP*DW-1:0] rd_data_bus;
  logic           err_clr = 1'b0;
  logic [DW-1:0]  in_port;
  logic [NP-1:0]  rd_sel, wr_sel;
  logic [DW-1:0]  wr_data;
  logic           err_flag;
  logic [AW-1:0]  err_addr;
  logic [7:0]     err_count;

  int checks = 0;
  int errors = 0;

  io_port_decoder #(.ADDR_W(AW), .DATA_W(DW), .NUM_PORTS(NP), .BASE_ADDR(8'h10)) dut (
    .clk(clk), .rst_n(rst_n), .port_id(port_id), .read_strobe(read_strobe),
    .write_strobe(write_strobe), .out_port(out_port), .rd_data_bus(rd_data_bus),
    .err_clr(err_clr), .in_port(in_port), .rd_sel(rd_sel), .wr_sel(wr_sel),
    .wr_data(wr_data), .err_flag(err_flag), .err_addr(err_addr), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  pid;
    logic        rd, wr;
    logic [7:0]  op;
    logic        clr;
    logic [15:0] wsel, rsel;
    logic [7:0]  wd, inp;
    logic        flag;
    logic [7:0]  eaddr, ecnt;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(logic [7:0] pid, logic rd, logic wr, logic [7:0] op, logic clr,
                              logic [15:0] wsel, logic [15:0] rsel, logic [7:0] wd,
                              logic [7:0] inp, logic flag, logic [7:0] eaddr, logic [7:0] ecnt);
    vec_t v;
    v.pid = pid; v.rd = rd; v.wr = wr; v.op = op; v.clr = clr;
    v.wsel = wsel; v.rsel = rsel; v.wd = wd; v.inp = inp;
    v.flag = flag; v.eaddr = eaddr; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [15:0] wsel, input logic [15:0] rsel,
                         input logic [7:0] wd, input logic [7:0] inp, input logic flag,
                         input logic [7:0] eaddr, input logic [7:0] ecnt);
    chk({tag, ".wr_sel"},    32'(wr_sel),    32'(wsel));
    chk({tag, ".rd_sel"},    32'(rd_sel),    32'(rsel));
    chk({tag, ".wr_data"},   32'(wr_data),   32'(wd));
    chk({tag, ".in_port"},   32'(in_port),   32'(inp));
    chk({tag, ".err_flag"},  32'(err_flag),  32'(flag));
    chk({tag, ".err_addr"},  32'(err_addr),  32'(eaddr));
    chk({tag, ".err_count"}, 32'(err_count), 32'(ecnt));
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < NP; k++) rd_data_bus[k*DW +: DW] = 8'(8'h2D + k);

    //        pid    rd wr op     clr  wsel     rsel     wd     in     f  eaddr  ecnt
    vecs[0]  = mk(8'h13, 0, 1, 8'hA5, 0, 16'h0008, 16'h0000, 8'hA5, 8'h30, 0, 8'h00, 8'd0);
    vecs[1]  = mk(8'h13, 0, 0, 8'h00, 0, 16'h0000, 16'h0000, 8'hA5, 8'h30, 0, 8'h00, 8'd0);
    vecs[2]  = mk(8'h1F, 1, 0, 8'h00, 0, 16'h0000, 16'h8000, 8'hA5, 8'h3C, 0, 8'h00, 8'd0);
    vecs[3]  = mk(8'h1F, 1, 0, 8'h00, 0, 16'h0000, 16'h0000, 8'hA5, 8'h3C, 0, 8'h00, 8'd0);
    vecs[4]  = mk(8'h1F, 1, 0, 8'h00, 0, 16'h0000, 16'h0000, 8'hA5, 8'h3C, 0, 8'h00, 8'd0);
    vecs[5]  = mk(8'h1F, 0, 0, 8'h00, 0, 16'h0000, 16'h0000, 8'hA5, 8'h3C, 0, 8'h00, 8'd0);
    vecs[6]  = mk(8'h20, 0, 1, 8'h77, 0, 16'h0000, 16'h0000, 8'hA5, 8'h00, 1, 8'h20, 8'd1);
    vecs[7]  = mk(8'h05, 0, 0, 8'h00, 0, 16'h0000, 16'h0000, 8'hA5, 8'h00, 1, 8'h20, 8'd1);
    vecs[8]  = mk(8'h05, 0, 1, 8'h11, 0, 16'h0000, 16'h0000, 8'hA5, 8'h00, 1, 8'h20, 8'd2);
    vecs[9]  = mk(8'h05, 0, 0, 8'h00, 1, 16'h0000, 16'h0000, 8'hA5, 8'h00, 0, 8'h00, 8'd0);
    vecs[10] = mk(8'h12, 1, 1, 8'h5A, 0, 16'h0004, 16'h0000, 8'h5A, 8'h2F, 1, 8'h12, 8'd1);
    vecs[11] = mk(8'h12, 0, 0, 8'h00, 0, 16'h0000, 16'h0000, 8'h5A, 8'h2F, 1, 8'h12, 8'd1);
    vecs[12] = mk(8'h10, 1, 0, 8'h00, 1, 16'h0000, 16'h0001, 8'h5A, 8'h2D, 0, 8'h00, 8'd0);
    vecs[13] = mk(8'h00, 0, 0, 8'h00, 0, 16'h0000, 16'h0000, 8'h5A, 8'h00, 0, 8'h00, 8'd0);
    vecs[14] = mk(8'h1A, 0, 1, 8'hC3, 0, 16'h0400, 16'h0000, 8'hC3, 8'h37, 0, 8'h00, 8'd0);
    vecs[15] = mk(8'h1A, 1, 1, 8'h99, 0, 16'h0000, 16'h0400, 8'hC3, 8'h37, 0, 8'h00, 8'd0);
    vecs[16] = mk(8'h0F, 0, 0, 8'h00, 0, 16'h0000, 16'h0000, 8'hC3, 8'h00, 0, 8'h00, 8'd0);

    // Reset state
    #1;
    chk_all("reset", 16'h0, 16'h0, 8'h00, 8'h00, 1'b0, 8'h00, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      port_id      = vecs[i].pid;
      read_strobe  = vecs[i].rd;
      write_strobe = vecs[i].wr;
      out_port     = vecs[i].op;
      err_clr      = vecs[i].clr;
      @(negedge clk);
      chk_all($sformatf("vec%0d", i), vecs[i].wsel, vecs[i].rsel, vecs[i].wd, vecs[i].inp,
              vecs[i].flag, vecs[i].eaddr, vecs[i].ecnt);
    end

    // Saturation: 260 misses at 0x05, first-error address must stick
    read_strobe = 1'b0; write_strobe = 1'b0; err_clr = 1'b0; port_id = 8'h05;
    @(negedge clk);
    for (int i = 0; i < 260; i++) begin
      write_strobe = 1'b1;
      @(negedge clk);
      write_strobe = 1'b0;
      @(negedge clk);
    end
    chk("sat.err_count", 32'(err_count), 32'd255);
    chk("sat.err_flag",  32'(err_flag),  32'd1);
    chk("sat.err_addr",  32'(err_addr),  32'h05);

    // Clear collides with a miss at 0x00: the event wins
    port_id = 8'h00; write_strobe = 1'b1; err_clr = 1'b1;
    @(negedge clk);
    chk("collide.err_flag",  32'(err_flag),  32'd1);
    chk("collide.err_count", 32'(err_count), 32'd1);
    chk("collide.err_addr",  32'(err_addr),  32'h00);
    chk("collide.wr_sel",    32'(wr_sel),    32'h0);
    write_strobe = 1'b0; err_clr = 1'b0;
    @(negedge clk);

    // Asynchronous reset during a wr_sel pulse, strobe still high at release
    port_id = 8'h15; out_port = 8'h6E; write_strobe = 1'b1;
    @(posedge clk);
    #1;
    chk("pre_rst.wr_sel", 32'(wr_sel), 32'h0020);
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 16'h0, 16'h0, 8'h00, 8'h00, 1'b0, 8'h00, 8'd0);
    @(negedge clk);
    chk("in_rst.wr_sel", 32'(wr_sel), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst.wr_sel",  32'(wr_sel),  32'h0020);
    chk("post_rst.wr_data", 32'(wr_data), 32'h6E);
    chk("post_rst.in_port", 32'(in_port), 32'h32);
    @(negedge clk);
    chk("post_rst_hold.wr_sel", 32'(wr_sel), 32'h0);
    write_strobe = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_port_decoder.md
# io_port_decoder

Parametrised, registered successor to the PicoBlaze port-ID strobe decoder. It decodes `port_id` within a configurable address window into one-cycle, edge-qualified read/write select pulses, and captures `out_port` alongside each write pulse. It returns a registered read-data mux on `in_port`, and logs out-of-window or conflicting accesses in a sticky error register. It sits between the PicoBlaze core and the UART, timer and GPIO peripherals in CoreLogic.

## Interface
Parameters:
- `ADDR_W`, 8, width of `port_id`.
- `DATA_W`, 8, width of the data buses.
- `NUM_PORTS`, 16, number of decoded ports; legal range is 1..2^ADDR_W.
- `BASE_ADDR`, 0, first decoded address; the window is [BASE_ADDR, BASE_ADDR+NUM_PORTS-1] and must fit within ADDR_W.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `port_id`  in  ADDR_W  PicoBlaze port address.
- `read_strobe`  in  1  PicoBlaze read strobe.
- `write_strobe`  in  1  PicoBlaze write strobe.
- `out_port`  in  DATA_W  PicoBlaze write data.
- `rd_data_bus`  in  NUM_PORTS*DATA_W  peripheral read data; port k occupies bits [k*DATA_W +: DATA_W].
- `err_clr`  in  1  clears the error log.
- `in_port`  out  DATA_W  registered read data to the PicoBlaze.
- `rd_sel`  out  NUM_PORTS  one-hot read pulse.
- `wr_sel`  out  NUM_PORTS  one-hot write pulse.
- `wr_data`  out  DATA_W  write data captured with `wr_sel`.
- `err_flag`  out  1  sticky access-error flag.
- `err_addr`  out  ADDR_W  `port_id` of the first error since the last clear.
- `err_count`  out  8  number of error events, saturating.

## Operation
- **Hit and index.** `hit = (port_id >= BASE_ADDR) && (port_id - BASE_ADDR < NUM_PORTS)`. `idx = port_id - BASE_ADDR`, computed at ADDR_W+1 bits to avoid wrap-around.
- **Edge qualification.** Registered copies `rd_q` and `wr_q` of the strobes hold last cycle's value. An event is `rd_ev = read_strobe & ~rd_q` or `wr_ev = write_strobe & ~wr_q`. A strobe held for several cycles yields exactly one event.
- **Write event.**
  - If `wr_ev & hit`: `wr_sel[idx]` = 1 for one cycle and `wr_data <= out_port`.
  - `wr_data` holds its value between writes.
- **Read event.**
  - If `rd_ev & hit & ~wr_ev`: `rd_sel[idx]` = 1 for one cycle. Peripherals use this pulse as a pop or acknowledge.
- **Simultaneous `rd_ev` and `wr_ev`.**
  - The write proceeds if `hit`.
  - The read is suppressed.
  - An error event is logged.
- **Read data.**
  - Every cycle, `in_port <= hit ? rd_data_bus[idx] : 0`.
  - The register updates independently of the strobes.
- **Error event.** Raised when `(rd_ev | wr_ev) & ~hit`, or when `rd_ev & wr_ev`. On an error event:
  - `err_flag <= 1`.
  - `err_addr <= port_id`, but only if `err_flag` was 0, so the first error is kept.
  - `err_count` increments, saturating at 255.
- **Error clear.**
  - `err_clr` alone: `err_flag`, `err_addr` and `err_count` all go to 0.
  - `err_clr` and an error event in the same cycle: the event wins over the clear. Result is `err_flag`=1, `err_addr`=current `port_id`, `err_count`=1.
- **Reset.**
  - All outputs go to 0: `in_port`, `rd_sel`, `wr_sel`, `wr_data`, `err_flag`, `err_addr`, `err_count`.
  - `rd_q` and `wr_q` go to 0.
  - A strobe already high when reset releases is counted as an event on the first clock after release.
- **NUM_PORTS = 1.** `idx` is always 0 on a hit; the selects are 1 bit wide.

## Timing
- **Strobe to select.** A strobe edge sampled at clock edge N makes `rd_sel`/`wr_sel` high from edge N through edge N+1, exactly one cycle. `wr_data` is valid in that same cycle.
- **Read data.** `port_id` stable at edge N gives `in_port` valid after edge N, a latency of 1 cycle. This meets the PicoBlaze two-cycle INPUT capture with no wait state.
- **Error log.** `err_flag`, `err_addr` and `err_count` update at the same edge as the selects.
- **Back-to-back access.** A strobe must drop for at least one cycle between accesses before a new event is recognised. Consecutive PicoBlaze I/O instructions always satisfy this.
- **No combinational paths.** No input reaches any output combinationally.
- **Asynchronous reset.** Asserting `rst_n` low clears outputs immediately, including mid-pulse. Any select pulse in flight is lost.

## Test plan
- **Write hit.** BASE_ADDR=0x10, NUM_PORTS=16; `port_id`=0x13, `out_port`=0xA5, `write_strobe` high for 1 cycle -> `wr_sel`=0x0008 for exactly 1 cycle, `wr_data`=0xA5, `err_flag`=0.
- **Held read strobe.** `port_id`=0x1F, `read_strobe` held 3 cycles, port 15 data=0x3C -> `rd_sel[15]` pulses once; `in_port`=0x3C one cycle after `port_id` is applied.
- **Out-of-window write, then clear.** `write_strobe` at `port_id`=0x20 -> no select; `err_flag`=1, `err_addr`=0x20, `err_count`=1. A second miss at 0x05 gives `err_addr` still 0x20 and `err_count`=2. `err_clr` then returns all three to 0.
- **Simultaneous read and write.** Both strobes rise at 0x12 -> `wr_sel[2]` pulses, `rd_sel` stays 0, `err_count` +1.
- **Saturation and clear/event collision.** 260 miss events -> `err_count`=255. Then `err_clr` in the same cycle as a miss at 0x00 -> `err_flag`=1, `err_count`=1, `err_addr`=0x00.
- **Reset mid-operation.** `rst_n` low during the `wr_sel` cycle -> all outputs 0 immediately. With `write_strobe` still high at release, one `wr_sel` pulse occurs on the first clock after release.
